// File: rtl/bpu_pkg.sv
// bpu_pkg: shared 2-bit direction-counter encodings and saturating update
package bpu_pkg;
    typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} ctr_e;
    localparam logic [1:0] PHT_RESET = WNT;
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        return taken ? (c == ST ? c : c + 2'd1) : (c == SNT ? c : c - 2'd1);
    endfunction
endpackage

// File: rtl/gshare_pht.sv
// gshare_pht: pattern history table of 2-bit saturating direction counters
module gshare_pht
    import bpu_pkg::*;
#(
    parameter int INDEX_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  logic                  i_wr_taken,
    output logic                  o_rd_taken
);
    logic [1:0] r_pht [1 << INDEX_BITS];
    assign o_rd_taken = r_pht[i_rd_idx][1];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << INDEX_BITS); i++) r_pht[i] <= PHT_RESET;
        end else if (i_wr_en) begin
            r_pht[i_wr_idx] <= ctr_next(r_pht[i_wr_idx], i_wr_taken);
        end
    end
endmodule

// File: rtl/gshare_bpu.sv
// gshare_bpu: BTB + gshare direction predictor with global history and perf counters
module gshare_bpu
    import bpu_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int HIST_BITS  = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        upd_valid,
    input  logic        upd_is_cond,
    input  logic        upd_taken,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] next_pc,
    output logic        pred_taken,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int N  = 1 << INDEX_BITS;
    localparam int TW = 30 - INDEX_BITS;
    logic                  r_valid   [N];
    logic                  r_is_jump [N];
    logic [TW-1:0]         r_tag     [N];
    logic [31:0]           r_target  [N];
    logic [HIST_BITS-1:0]  r_ghr;
    logic [31:0]           r_branch_cnt, r_mispred_cnt;
    logic [INDEX_BITS-1:0] w_idx, w_upd_idx, w_ghr_ext;
    logic [TW-1:0]         w_tag, w_upd_tag;
    logic                  w_hit, w_pht_taken, w_unused;
    assign w_idx       = pc[INDEX_BITS+1:2];
    assign w_tag       = pc[31:INDEX_BITS+2];
    assign w_upd_idx   = upd_pc[INDEX_BITS+1:2];
    assign w_upd_tag   = upd_pc[31:INDEX_BITS+2];
    assign w_ghr_ext   = INDEX_BITS'(r_ghr);
    assign w_unused    = ^{pc[1:0], upd_pc[1:0]};
    assign w_hit       = r_valid[w_idx] && r_tag[w_idx] == w_tag;
    // Gated by reset so stale or uninitialised state never leaks out while reset is held
    assign pred_taken  = !reset && w_hit && (r_is_jump[w_idx] || w_pht_taken);
    assign next_pc     = pred_taken ? r_target[w_idx] : pc + 32'd4;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
    gshare_pht #(.INDEX_BITS(INDEX_BITS)) u_pht (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (w_idx ^ w_ghr_ext),
        .i_wr_en    (upd_valid && upd_is_cond),
        .i_wr_idx   (w_upd_idx ^ w_ghr_ext),
        .i_wr_taken (upd_taken),
        .o_rd_taken (w_pht_taken)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) r_valid[i] <= 1'b0;
            r_ghr         <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                r_valid[w_upd_idx]   <= 1'b1;
                r_tag[w_upd_idx]     <= w_upd_tag;
                r_target[w_upd_idx]  <= upd_target;
                r_is_jump[w_upd_idx] <= !upd_is_cond;
            end
            if (upd_is_cond) begin
                r_ghr        <= HIST_BITS'({r_ghr, upd_taken});
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (upd_mispredict) r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end
endmodule
